// File: rtl/pll_sequencer.sv
// PLL power-up sequencer: reset hold, lock wait with retries, stability
// qualification, run monitoring and a terminal bypass fallback.
module pll_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4800,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_in,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        BYPASS     = 3'd4
    } state_t;

    localparam logic [15:0] RC_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] LS_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [1:0]  MR      = 2'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  retry_d;
    logic        fault_d;
    logic        resetb_d, bypass_d, sys_rst_d, ready_d;
    logic        lock_q1, lock_s;

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        retry_d = retry_count;
        fault_d = fault;
        if (restart) begin
            state_d = RESET_HOLD;
            retry_d = 2'd0;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                RESET_HOLD: begin
                    if (cnt_q == RC_LAST)
                        state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == LT_LAST) begin
                        if (retry_count == MR) begin
                            state_d = BYPASS;
                            fault_d = 1'b1;
                        end else begin
                            state_d = RESET_HOLD;
                            retry_d = retry_count + 2'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == LS_LAST) begin
                        state_d = RUN;
                        retry_d = 2'd0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RESET_HOLD;
                        fault_d = 1'b1;
                    end
                end
                BYPASS: begin
                    state_d = BYPASS;
                end
                default: state_d = RESET_HOLD;
            endcase
        end
        if (restart || state_d != state_q)
            cnt_d = 16'd0;
    end

    // Outputs decode the next state so they change on the transition edge
    always_comb begin
        resetb_d  = 1'b0;
        bypass_d  = 1'b0;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        unique case (state_d)
            WAIT_LOCK, STABLE: begin
                resetb_d = 1'b1;
            end
            RUN: begin
                resetb_d  = 1'b1;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            BYPASS: begin
                bypass_d  = 1'b1;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: begin
                resetb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q1     <= 1'b0;
            lock_s      <= 1'b0;
            state_q     <= RESET_HOLD;
            cnt_q       <= 16'd0;
            retry_count <= 2'd0;
            fault       <= 1'b0;
            pll_resetb  <= 1'b0;
            pll_bypass  <= 1'b0;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
        end else begin
            lock_q1     <= lock_in;
            lock_s      <= lock_q1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_count <= retry_d;
            fault       <= fault_d;
            pll_resetb  <= resetb_d;
            pll_bypass  <= bypass_d;
            sys_rst     <= sys_rst_d;
            ready       <= ready_d;
        end
    end

endmodule
